// File: rtl/ps2_reg_writer.sv
// ps2_reg_writer: PS/2 keyboard front end that loads hex values into the CPU
// register file. Deserializes PS/2 frames, decodes set-2 make codes for hex
// digits and Enter/Backspace/Esc, and runs a SEL -> ENTRY -> WRITE entry FSM.
//
// Ports:
//   CLOCK_50     in   system clock (sole clock)
//   resetn       in   asynchronous active-low reset
//   PS2_CLK      in   raw keyboard clock (asynchronous)
//   PS2_DAT      in   raw keyboard data (asynchronous)
//   we           out  register file write enable, one-cycle pulse
//   wa           out  write address, valid while we=1, else 0
//   wd           out  write data, valid while we=1, else 0
//   sel_reg      out  selected register, 0 when none
//   entry_value  out  hex digit accumulator
//   digit_count  out  digits entered, 0..8
//   frame_err    out  one-cycle pulse on framing/parity/timeout error
//
// Build option: define PS2_PARITY_CHECK_EN to enable odd-parity checking;
// otherwise the parity bit is sampled but ignored.
module ps2_reg_writer #(
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic        CLOCK_50,
   input  logic        resetn,
   input  logic        PS2_CLK,
   input  logic        PS2_DAT,
   output logic        we,
   output logic [2:0]  wa,
   output logic [31:0] wd,
   output logic [2:0]  sel_reg,
   output logic [31:0] entry_value,
   output logic [3:0]  digit_count,
   output logic        frame_err
);

   localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {ST_SEL, ST_ENTRY, ST_WRITE} state_t;

   // Set-2 make code -> {is_digit, value}
   function automatic logic [4:0] hex_decode(input logic [7:0] c);
      logic [4:0] r;
      case (c)
         8'h45: r = 5'h10;  8'h16: r = 5'h11;  8'h1E: r = 5'h12;  8'h26: r = 5'h13;
         8'h25: r = 5'h14;  8'h2E: r = 5'h15;  8'h36: r = 5'h16;  8'h3D: r = 5'h17;
         8'h3E: r = 5'h18;  8'h46: r = 5'h19;  8'h1C: r = 5'h1A;  8'h32: r = 5'h1B;
         8'h21: r = 5'h1C;  8'h23: r = 5'h1D;  8'h24: r = 5'h1E;  8'h2B: r = 5'h1F;
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   logic              clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
   logic              dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic [9:0]        shift_q, shift_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic              code_valid_q, code_valid_d;
   logic [7:0]        code_q, code_d;
   logic              frame_err_q, frame_err_d;
   logic              brk_q, brk_d;
   state_t            state_q, state_d;
   logic [2:0]        sel_q, sel_d;
   logic [31:0]       value_q, value_d;
   logic [3:0]        count_q, count_d;
   logic              we_q, we_d;
   logic [2:0]        wa_q, wa_d;
   logic [31:0]       wd_q, wd_d;

   logic              fall_c, frame_ok_c, key_valid_c, is_digit_c;
   logic [3:0]        digit_c;
   logic [4:0]        dec_c;

   // State register
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         clk_s1_q     <= 1'b0;
         clk_s2_q     <= 1'b0;
         clk_prev_q   <= 1'b0;
         dat_s1_q     <= 1'b0;
         dat_s2_q     <= 1'b0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         idle_q       <= '0;
         code_valid_q <= 1'b0;
         code_q       <= '0;
         frame_err_q  <= 1'b0;
         brk_q        <= 1'b0;
         state_q      <= ST_SEL;
         sel_q        <= '0;
         value_q      <= '0;
         count_q      <= '0;
         we_q         <= 1'b0;
         wa_q         <= '0;
         wd_q         <= '0;
      end else begin
         clk_s1_q     <= clk_s1_d;
         clk_s2_q     <= clk_s2_d;
         clk_prev_q   <= clk_prev_d;
         dat_s1_q     <= dat_s1_d;
         dat_s2_q     <= dat_s2_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         idle_q       <= idle_d;
         code_valid_q <= code_valid_d;
         code_q       <= code_d;
         frame_err_q  <= frame_err_d;
         brk_q        <= brk_d;
         state_q      <= state_d;
         sel_q        <= sel_d;
         value_q      <= value_d;
         count_q      <= count_d;
         we_q         <= we_d;
         wa_q         <= wa_d;
         wd_q         <= wd_d;
      end
   end

   // Receiver: synchronize, detect falling edge, assemble and check frames
   always_comb begin
      clk_s1_d     = PS2_CLK;
      clk_s2_d     = clk_s1_q;
      clk_prev_d   = clk_s2_q;
      dat_s1_d     = PS2_DAT;
      dat_s2_d     = dat_s1_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      idle_d       = (idle_q == IDLE_W'(TIMEOUT_CYCLES)) ? idle_q : idle_q + IDLE_W'(1);
      code_valid_d = 1'b0;
      code_d       = code_q;
      frame_err_d  = 1'b0;

      fall_c = clk_prev_q & ~clk_s2_q;
      // shift_q[0]=start, [8:1]=data, [9]=parity; the stop bit is the live sample
`ifdef PS2_PARITY_CHECK_EN
      frame_ok_c = ~shift_q[0] & dat_s2_q & (^shift_q[9:1]);
`else
      frame_ok_c = ~shift_q[0] & dat_s2_q;
`endif

      // An edge takes priority over a coincident timeout
      if (fall_c) begin
         idle_d = '0;
         if (bit_cnt_q == 4'd10) begin
            bit_cnt_d = '0;
            if (frame_ok_c) begin
               code_valid_d = 1'b1;
               code_d       = shift_q[8:1];
            end else begin
               frame_err_d = 1'b1;
            end
         end else begin
            shift_d   = {dat_s2_q, shift_q[9:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
         end
      end else if (idle_q == IDLE_W'(TIMEOUT_CYCLES) && bit_cnt_q != 4'd0) begin
         bit_cnt_d   = '0;
         frame_err_d = 1'b1;
      end
   end

   // Decoder and entry FSM
   always_comb begin
      brk_d   = brk_q;
      state_d = state_q;
      sel_d   = sel_q;
      value_d = value_q;
      count_d = count_q;
      we_d    = 1'b0;
      wa_d    = '0;
      wd_d    = '0;

      dec_c      = hex_decode(code_q);
      is_digit_c = dec_c[4];
      digit_c    = dec_c[3:0];

      // Break prefix swallows the following release byte
      key_valid_c = code_valid_q && !brk_q && code_q != 8'hF0 && code_q != 8'hE0;
      if (code_valid_q) begin
         if (code_q == 8'hF0) brk_d = 1'b1;
         else if (brk_q)      brk_d = 1'b0;
      end

      case (state_q)
         ST_SEL: begin
            // R0 is hardwired zero, so only 1..7 are selectable
            if (key_valid_c && is_digit_c && !digit_c[3] && digit_c[2:0] != 3'd0) begin
               sel_d   = digit_c[2:0];
               value_d = '0;
               count_d = '0;
               state_d = ST_ENTRY;
            end
         end
         ST_ENTRY: begin
            if (key_valid_c) begin
               if (is_digit_c) begin
                  if (count_q < 4'd8) begin
                     value_d = {value_q[27:0], digit_c};
                     count_d = count_q + 4'd1;
                  end
               end else if (code_q == 8'h5A) begin
                  if (count_q != 4'd0) begin
                     state_d = ST_WRITE;
                     we_d    = 1'b1;
                     wa_d    = sel_q;
                     wd_d    = value_q;
                  end
               end else if (code_q == 8'h66) begin
                  if (count_q != 4'd0) begin
                     value_d = value_q >> 4;
                     count_d = count_q - 4'd1;
                  end else begin
                     state_d = ST_SEL;
                     sel_d   = '0;
                  end
               end else if (code_q == 8'h76) begin
                  state_d = ST_SEL;
                  sel_d   = '0;
                  value_d = '0;
                  count_d = '0;
               end
            end
         end
         ST_WRITE: begin
            // entry_value is kept so the written value stays visible
            state_d = ST_SEL;
            sel_d   = '0;
            count_d = '0;
         end
         default: state_d = ST_SEL;
      endcase
   end

   assign we          = we_q;
   assign wa          = wa_q;
   assign wd          = wd_q;
   assign sel_reg     = sel_q;
   assign entry_value = value_q;
   assign digit_count = count_q;
   assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_reg_writer.sv
// Testbench for ps2_reg_writer: drives PS/2 frames and compares outputs with
// a keystroke-level model of the register entry rules.
module tb_ps2_reg_writer;

   localparam int TIMEOUT = 50000;
   localparam int HALF    = 8;
   localparam int GAP     = 24;

   logic        CLOCK_50;
   logic        resetn;
   logic        PS2_CLK;
   logic        PS2_DAT;
   logic        we;
   logic [2:0]  wa;
   logic [31:0] wd;
   logic [2:0]  sel_reg;
   logic [31:0] entry_value;
   logic [3:0]  digit_count;
   logic        frame_err;

   ps2_reg_writer #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .CLOCK_50(CLOCK_50), .resetn(resetn), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
      .we(we), .wa(wa), .wd(wd), .sel_reg(sel_reg), .entry_value(entry_value),
      .digit_count(digit_count), .frame_err(frame_err)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   int errors = 0;
   int checks = 0;

   logic [7:0] dig_codes [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                  8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
   logic [7:0] pool [20] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                             8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
                             8'h5A, 8'h66, 8'h76, 8'h1A};

   // Model state: selected register (0 = none), accumulator, digit count
   int          m_sel = 0;
   logic [31:0] m_val = '0;
   int          m_cnt = 0;
   int          exp_ferr = 0;
   logic [34:0] expq [$];
   logic [34:0] capq [$];

   // Bus monitor
   int   bad_idle = 0;
   int   wide = 0;
   int   ferr_seen = 0;
   logic prev_we = 1'b0;
   always @(negedge CLOCK_50) begin
      if (we === 1'b1) capq.push_back({wa, wd});
      else if (wa !== 3'd0 || wd !== 32'd0) bad_idle++;
      if (we === 1'b1 && prev_we === 1'b1) wide++;
      if (frame_err === 1'b1) ferr_seen++;
      prev_we = we;
   end

   function automatic int digit_of(input logic [7:0] c);
      for (int i = 0; i < 16; i++) if (dig_codes[i] == c) return i;
      return -1;
   endfunction

   task automatic model_key(input logic [7:0] c);
      int d;
      d = digit_of(c);
      if (m_sel == 0) begin
         if (d >= 1 && d <= 7) begin m_sel = d; m_val = '0; m_cnt = 0; end
      end else if (d >= 0) begin
         if (m_cnt < 8) begin m_val = m_val * 16 + 32'(d); m_cnt++; end
      end else if (c == 8'h5A) begin
         if (m_cnt > 0) begin expq.push_back({3'(m_sel), m_val}); m_sel = 0; m_cnt = 0; end
      end else if (c == 8'h66) begin
         if (m_cnt > 0) begin m_val = m_val / 16; m_cnt--; end
         else m_sel = 0;
      end else if (c == 8'h76) begin
         m_sel = 0; m_val = '0; m_cnt = 0;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".sel_reg"}, 64'(sel_reg), 64'(m_sel));
      chk({tag, ".entry_value"}, 64'(entry_value), 64'(m_val));
      chk({tag, ".digit_count"}, 64'(digit_count), 64'(m_cnt));
      chk({tag, ".writes"}, 64'(capq.size()), 64'(expq.size()));
      if (capq.size() == expq.size()) begin
         while (expq.size() > 0) chk({tag, ".wa_wd"}, 64'(capq.pop_front()), 64'(expq.pop_front()));
      end else begin
         capq.delete();
         expq.delete();
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".we"}, 64'(we), 64'd0);
      chk({tag, ".wa"}, 64'(wa), 64'd0);
      chk({tag, ".wd"}, 64'(wd), 64'd0);
      chk({tag, ".sel_reg"}, 64'(sel_reg), 64'd0);
      chk({tag, ".entry_value"}, 64'(entry_value), 64'd0);
      chk({tag, ".digit_count"}, 64'(digit_count), 64'd0);
      chk({tag, ".frame_err"}, 64'(frame_err), 64'd0);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge CLOCK_50) PS2_DAT = f[i];
         repeat (HALF) @(negedge CLOCK_50);
         PS2_CLK = 1'b0;
         repeat (HALF) @(negedge CLOCK_50);
         PS2_CLK = 1'b1;
      end
      @(negedge CLOCK_50) PS2_DAT = 1'b1;
      repeat (GAP) @(negedge CLOCK_50);
   endtask

   task automatic press(input logic [7:0] c, input bit rel);
      send_frame(c, 1'b0, 11);
      if (rel) begin
         send_frame(8'hF0, 1'b0, 11);
         send_frame(c, 1'b0, 11);
      end
      model_key(c);
   endtask

   initial begin
      logic [7:0] seq2 [11] = '{8'h26, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                8'h3E, 8'h46, 8'h5A};
      resetn  = 1'b0;
      PS2_CLK = 1'b1;
      PS2_DAT = 1'b1;
      repeat (4) @(negedge CLOCK_50);
      check_zero("reset");
      resetn = 1'b1;
      repeat (4) @(negedge CLOCK_50);

      // Select R2, type A B, Enter, all with release codes
      press(8'h1E, 1'b1); check_state("s1_sel");
      press(8'h1C, 1'b1); check_state("s1_a");
      press(8'h32, 1'b1); check_state("s1_b");
      press(8'h5A, 1'b1); check_state("s1_enter");

      // Nine digits: the ninth is dropped
      foreach (seq2[i]) begin
         press(seq2[i], 1'b0);
         check_state("s2");
      end

      // Backspace editing, then Esc abort
      press(8'h2E, 1'b0); press(8'h1C, 1'b0); press(8'h32, 1'b0);
      press(8'h66, 1'b0); check_state("s3_bksp");
      press(8'h21, 1'b0); press(8'h5A, 1'b0); check_state("s3_enter");
      press(8'h25, 1'b0); press(8'h2B, 1'b0); press(8'h76, 1'b0); check_state("s3_esc");
      press(8'h5A, 1'b0); check_state("s3_enter_after_esc");

      // Digit 0 cannot select R0
      press(8'h45, 1'b0); press(8'h5A, 1'b0); check_state("s4");

      // Corrupted parity on code 16
      send_frame(8'h16, 1'b1, 11);
`ifdef PS2_PARITY_CHECK_EN
      exp_ferr++;
`else
      model_key(8'h16);
`endif
      check_state("parity");
      chk("parity.ferr", 64'(ferr_seen), 64'(exp_ferr));
      press(8'h76, 1'b0); check_state("parity_esc");

      // Partial frame then idle past the timeout
      send_frame(8'h16, 1'b0, 5);
      repeat (TIMEOUT + 100) @(negedge CLOCK_50);
      exp_ferr++;
      chk("timeout.ferr", 64'(ferr_seen), 64'(exp_ferr));
      press(8'h16, 1'b1); check_state("after_timeout");
      press(8'h76, 1'b0); check_state("after_timeout_esc");

      // Random keystrokes
      for (int k = 0; k < 15; k++) begin
         press(pool[$urandom_range(0, 19)], 1'($urandom_range(0, 1)));
         check_state("rand");
      end
      press(8'h76, 1'b0); check_state("rand_esc");

      // Reset in the middle of an Enter frame
      press(8'h36, 1'b0); press(8'h3D, 1'b0); check_state("rst_pre");
      send_frame(8'h5A, 1'b0, 6);
      resetn = 1'b0;
      #1;
      check_zero("rst_mid");
      m_sel = 0; m_val = '0; m_cnt = 0;
      repeat (3) @(negedge CLOCK_50);
      resetn = 1'b1;
      repeat (200) @(negedge CLOCK_50);
      check_state("rst_post");
      check_zero("rst_post");

      chk("mon.idle_bus", 64'(bad_idle), 64'd0);
      chk("mon.we_width", 64'(wide), 64'd0);
      chk("mon.ferr", 64'(ferr_seen), 64'(exp_ferr));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
